cnt_bcd_disp_driver: RTL

CNT_BCD_DISP_DRIVER -- requirements
Module: cnt_bcd_disp_driver

---
 rtl/cnt_bcd_disp_driver.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cnt_bcd_disp_driver.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a multiplexed 7-segment display driver.
// A new conversion starts every NUM_BITS+2 cycles; the display scan runs independently.
`timescale 1ns/1ps
module cnt_bcd_disp_driver #(
   parameter int unsigned NUM_BITS    = 8,
   parameter int unsigned NUM_DIGITS  = 3,
   parameter int unsigned REFRESH_DIV = 1000,
   parameter bit          ACTIVE_LOW  = 1'b0,
   parameter bit          LZ_BLANK    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_BITS-1:0]     cnt_val,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    bcd_valid,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_en
);

   localparam int unsigned BcdW = 4 * NUM_DIGITS;
   localparam int unsigned CntW = $clog2(NUM_BITS + 1);
   localparam int unsigned RefW = $clog2(REFRESH_DIV);
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CntW-1:0]       CntLoad = CntW'(NUM_BITS);
   localparam logic [CntW-1:0]       CntOne  = CntW'(1);
   localparam logic [RefW-1:0]       RefMax  = RefW'(REFRESH_DIV - 1);
   localparam logic [RefW-1:0]       RefOne  = RefW'(1);
   localparam logic [IdxW-1:0]       IdxMax  = IdxW'(NUM_DIGITS - 1);
   localparam logic [IdxW-1:0]       IdxOne  = IdxW'(1);
   localparam logic [6:0]            Pol7    = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] PolD    = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]            SegRst  = 7'h3F ^ Pol7;
   localparam logic [NUM_DIGITS-1:0] DigRst  = NUM_DIGITS'(1) ^ PolD;

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e                state_q, state_d;
   logic [NUM_BITS-1:0]   bin_q, bin_d;
   logic [BcdW-1:0]       scr_q, scr_d;
   logic [BcdW-1:0]       adj;
   logic [CntW-1:0]       bitcnt_q, bitcnt_d;
   logic [BcdW-1:0]       bcd_q, bcd_d;
   logic                  valid_q, valid_d;

   logic [RefW-1:0]       ref_q, ref_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [3:0]            nib;
   logic                  blank;
   logic [6:0]            seg_ah;
   logic [NUM_DIGITS-1:0] en_ah;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] dig_en_q;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   // Add-3 correction applied before each shift so every nibble stays a valid BCD digit.
   always_comb begin
      adj = scr_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      scr_d    = scr_q;
      bitcnt_d = bitcnt_q;
      bcd_d    = bcd_q;
      valid_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            bin_d    = cnt_val;
            scr_d    = '0;
            bitcnt_d = CntLoad;
            state_d  = StConv;
         end
         StConv: begin
            scr_d    = {adj[BcdW-2:0], bin_q[NUM_BITS-1]};
            bin_d    = bin_q << 1;
            bitcnt_d = bitcnt_q - CntOne;
            if (bitcnt_q == CntOne) begin
               state_d = StDone;
            end
         end
         StDone: begin
            bcd_d   = scr_q;
            valid_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         bin_q    <= '0;
         scr_q    <= '0;
         bitcnt_q <= '0;
         bcd_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         scr_q    <= scr_d;
         bitcnt_q <= bitcnt_d;
         bcd_q    <= bcd_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      ref_d = ref_q + RefOne;
      idx_d = idx_q;
      if (ref_q == RefMax) begin
         ref_d = '0;
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxOne;
      end
   end

   // Decode from the stable bcd_q; a digit blanks only when it and everything above it is zero.
   always_comb begin
      nib   = '0;
      en_ah = '0;
      blank = LZ_BLANK && (idx_q != '0);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IdxW'(i) == idx_q) begin
            nib      = bcd_q[4*i +: 4];
            en_ah[i] = 1'b1;
         end
         if ((IdxW'(i) >= idx_q) && (bcd_q[4*i +: 4] != 4'd0)) begin
            blank = 1'b0;
         end
      end
      seg_ah = blank ? 7'h00 : seg7(nib);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q    <= '0;
         idx_q    <= '0;
         seg_q    <= SegRst;
         dig_en_q <= DigRst;
      end else begin
         ref_q    <= ref_d;
         idx_q    <= idx_d;
         seg_q    <= seg_ah ^ Pol7;
         dig_en_q <= en_ah ^ PolD;
      end
   end

   assign bcd_out   = bcd_q;
   assign bcd_valid = valid_q;
   assign seg       = seg_q;
   assign dig_en    = dig_en_q;

endmodule
